// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and defaults for the RVS192 hazard controller
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FW_BUBBLE  = 2'd1,
    MEM_WAIT   = 2'd2,
    FETCH_WAIT = 2'd3
  } hz_state_t;
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;
  localparam int HZ_MAX_STALL_CYC = 200;
endpackage

// File: rtl/pipeline_hazard_ctrl_watchdog.sv
// pipeline_hazard_ctrl_watchdog: consecutive-stall counter with sticky timeout flag
module pipeline_hazard_ctrl_watchdog #(
  parameter int STALL_CNT_W   = 8,
  parameter int MAX_STALL_CYC = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic stall_timeout
);
  logic [STALL_CNT_W-1:0] cnt;
  // count consecutive stalled cycles (saturating) and latch the timeout once reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      stall_timeout <= 1'b0;
    end else begin
      cnt           <= !stall ? '0 : (&cnt ? cnt : cnt + 1'b1);
      stall_timeout <= stall_timeout | (stall && cnt == STALL_CNT_W'(MAX_STALL_CYC - 1));
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RVS192 stall/flush controller; HZ_PERF_CNT_EN adds performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
`ifdef HZ_PERF_CNT_EN
  parameter int PERF_CNT_W    = 32,
`endif
  parameter int STALL_CNT_W   = 8,
  parameter int MAX_STALL_CYC = HZ_MAX_STALL_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fw_halt,
  input  logic       br_mispredict,
  input  logic       icache_stall,
  input  logic       dcache_stall,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       stall_timeout,
`ifdef HZ_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] perf_fw_bubbles,
  output logic [PERF_CNT_W-1:0] perf_flushes,
  output logic [PERF_CNT_W-1:0] perf_mem_stall,
`endif
  output logic [1:0] hz_state
);
  hz_state_t   state, nxt;
  stage_ctrl_t if_id, id_ex, ex_mem;
  logic        pc, mem_wb, fw_take, br_take;
  // a halt right after its own bubble is the same hazard, so it is masked in FW_BUBBLE
  assign fw_take = !dcache_stall && fw_halt && state != FW_BUBBLE;
  assign br_take = !dcache_stall && !fw_take && br_mispredict;
  // prioritised per-cycle control: dcache > fw_halt > mispredict > icache > normal; reset forces bubbles
  always_comb begin
    nxt    = RUN;
    pc     = 1'b1;
    mem_wb = 1'b1;
    if_id  = '{en: 1'b1, flush: 1'b0};
    id_ex  = '{en: 1'b1, flush: 1'b0};
    ex_mem = '{en: 1'b1, flush: 1'b0};
    if (dcache_stall) begin
      nxt       = MEM_WAIT;
      pc        = 1'b0;
      mem_wb    = 1'b0;
      if_id.en  = 1'b0;
      id_ex.en  = 1'b0;
      ex_mem.en = 1'b0;
    end else if (fw_take) begin
      nxt          = FW_BUBBLE;
      pc           = 1'b0;
      if_id.en     = 1'b0;
      id_ex.en     = 1'b0;
      ex_mem.flush = 1'b1;
    end else if (br_mispredict) begin
      if_id.flush = 1'b1;
      id_ex.flush = 1'b1;
    end else if (icache_stall) begin
      nxt         = FETCH_WAIT;
      pc          = 1'b0;
      if_id.en    = 1'b0;
      id_ex.flush = 1'b1;
    end
    if (rst) begin
      pc     = 1'b0;
      mem_wb = 1'b0;
      if_id  = '{en: 1'b0, flush: 1'b1};
      id_ex  = '{en: 1'b0, flush: 1'b1};
      ex_mem = '{en: 1'b0, flush: 1'b1};
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= nxt;
  end
  assign pc_en        = pc;
  assign if_id_en     = if_id.en;
  assign id_ex_en     = id_ex.en;
  assign ex_mem_en    = ex_mem.en;
  assign mem_wb_en    = mem_wb;
  assign if_id_flush  = if_id.flush;
  assign id_ex_flush  = id_ex.flush;
  assign ex_mem_flush = ex_mem.flush;
  assign hz_state     = state;
  pipeline_hazard_ctrl_watchdog #(
    .STALL_CNT_W  (STALL_CNT_W),
    .MAX_STALL_CYC(MAX_STALL_CYC)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .stall        (dcache_stall | icache_stall),
    .stall_timeout(stall_timeout)
  );
`ifdef HZ_PERF_CNT_EN
  // wrap-around event counters: bubbles inserted, mispredicts accepted, D-cache stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fw_bubbles <= '0;
      perf_flushes    <= '0;
      perf_mem_stall  <= '0;
    end else begin
      perf_fw_bubbles <= perf_fw_bubbles + PERF_CNT_W'(fw_take);
      perf_flushes    <= perf_flushes + PERF_CNT_W'(br_take);
      perf_mem_stall  <= perf_mem_stall + PERF_CNT_W'(dcache_stall);
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic fw_halt = 1'b0, br_mispredict = 1'b0, icache_stall = 1'b0, dcache_stall = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, stall_timeout;
  logic [1:0] hz_state;
`ifdef HZ_PERF_CNT_EN
  logic [31:0] perf_fw_bubbles, perf_flushes, perf_mem_stall;
`endif
  int vectors = 0, miscompares = 0;
  // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes}
  localparam logic [7:0] C_RST  = 8'b00000_111;
  localparam logic [7:0] C_NORM = 8'b11111_000;
  localparam logic [7:0] C_DC   = 8'b00000_000;
  localparam logic [7:0] C_FW   = 8'b00011_001;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_IC   = 8'b00111_010;

  pipeline_hazard_ctrl #(.STALL_CNT_W(8), .MAX_STALL_CYC(4)) dut (
    .clk(clk), .rst(rst), .fw_halt(fw_halt), .br_mispredict(br_mispredict),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .stall_timeout(stall_timeout),
`ifdef HZ_PERF_CNT_EN
    .perf_fw_bubbles(perf_fw_bubbles), .perf_flushes(perf_flushes), .perf_mem_stall(perf_mem_stall),
`endif
    .hz_state(hz_state)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic d, input logic f, input logic b, input logic i);
    dcache_stall = d; fw_halt = f; br_mispredict = b; icache_stall = i;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] ctl, input logic [1:0] st, input logic to);
    logic [10:0] obs, exp;
    obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, hz_state, stall_timeout};
    exp = {ctl, st, to};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s ctl/state/timeout observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0);
    chk("reset_hold", C_RST, 2'd0, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 0);        chk("post_reset", C_NORM, 2'd0, 1'b0);
    tick;
    drive(1, 0, 0, 0);        chk("dc_c1", C_DC, 2'd0, 1'b0);
    tick;                     chk("dc_c2", C_DC, 2'd2, 1'b0);
    tick;                     chk("dc_c3", C_DC, 2'd2, 1'b0);
    tick;                     chk("dc_c4", C_DC, 2'd2, 1'b0);
    tick;                     chk("dc_c5_timeout", C_DC, 2'd2, 1'b1);
    rst = 1'b1;
    #1;                       chk("rst_mid_stall", C_RST, 2'd0, 1'b0);
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 0);        chk("rst_release", C_NORM, 2'd0, 1'b0);
    tick;
    drive(0, 1, 0, 0);        chk("loaduse", C_FW, 2'd0, 1'b0);
    tick;                     chk("loaduse_masked", C_NORM, 2'd1, 1'b0);
    tick;
    drive(0, 0, 0, 0);        chk("loaduse_done", C_NORM, 2'd0, 1'b0);
    drive(1, 1, 0, 0);        chk("prio_c1", C_DC, 2'd0, 1'b0);
    tick;                     chk("prio_c2", C_DC, 2'd2, 1'b0);
    tick;                     chk("prio_c3", C_DC, 2'd2, 1'b0);
    tick;
    drive(0, 1, 0, 0);        chk("prio_bubble", C_FW, 2'd2, 1'b0);
    tick;                     chk("prio_after", C_NORM, 2'd1, 1'b0);
    tick;
    drive(0, 0, 1, 1);        chk("br_over_ic", C_BR, 2'd0, 1'b0);
    tick;
    drive(0, 0, 0, 0);        chk("br_next_run", C_NORM, 2'd0, 1'b0);
    drive(0, 1, 1, 0);        chk("br_with_fw", C_FW, 2'd0, 1'b0);
    tick;                     chk("br_in_bubble", C_BR, 2'd1, 1'b0);
    tick;
    drive(0, 0, 0, 0);        chk("br_bubble_run", C_NORM, 2'd0, 1'b0);
    drive(0, 0, 0, 1);        chk("ic_c1", C_IC, 2'd0, 1'b0);
    tick;                     chk("ic_c2", C_IC, 2'd3, 1'b0);
    tick;                     chk("ic_c3", C_IC, 2'd3, 1'b0);
    tick;                     chk("ic_c4_no_to", C_IC, 2'd3, 1'b0);
    tick;
    drive(0, 0, 0, 0);        chk("ic_timeout", C_NORM, 2'd3, 1'b1);
    tick;                     chk("timeout_sticky", C_NORM, 2'd0, 1'b1);
    drive(0, 1, 0, 0);        chk("fw_after_to", C_FW, 2'd0, 1'b1);
    tick;
    drive(0, 0, 0, 0);
`ifdef HZ_PERF_CNT_EN
    chk32("perf_fw_bubbles", perf_fw_bubbles, 32'd4);
    chk32("perf_flushes", perf_flushes, 32'd2);
    chk32("perf_mem_stall", perf_mem_stall, 32'd3);
`else
    chk32("default_state_run", {30'd0, hz_state}, 32'd1);
`endif
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
